// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared FSM encoding and character/segment constants for the digit scanner
package seg_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - byte input, shared-decoder and display signals of the digit scanner
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [7:0]        ivData;
    logic              iValid;
    logic              oReady;
    logic [7:0]        ovCharData;
    logic              oDecCE;
    logic [6:0]        ivSegments;
    logic [6:0]        ovSegments;
    logic [DIGITS-1:0] ovAnode;

    // master is the scanner itself; slave is the sender/decoder/display side
    modport master (
        input  ivData, iValid, ivSegments,
        output oReady, ovCharData, oDecCE, ovSegments, ovAnode
    );

    modport slave (
        output ivData, iValid, ivSegments,
        input  oReady, ovCharData, oDecCE, ovSegments, ovAnode
    );
endinterface

// File: rtl/seg_scan_tick.sv
// rtl/seg_scan_tick.sv - free-running prescaler, one-cycle tick on the last count of each slot
module seg_scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic iClk,
    input  logic iReset,
    output logic tick
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);
endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scanner feeding a shared ASCII decoder
// Optional line-editing (backspace / carriage return) via SEG_SCAN_CTRL_EDIT_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic             iClk,
    input  logic             iReset,
    seg_scan_ctrl_if.master  bus
);
    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

    state_t            state;
    state_t            state_nx;
    logic [IW-1:0]     index;
    logic [7:0]        char_buf [DIGITS];
    logic [DIGITS-1:0] anode;
    logic [6:0]        segs;
    logic              tick;
    logic              accept;

    seg_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .iClk   (iClk),
        .iReset (iReset),
        .tick   (tick)
    );

    assign accept = bus.iValid && bus.oReady;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_WAIT:   if (tick) state_nx = ST_LOAD;
            ST_LOAD:   state_nx = ST_SETTLE;
            ST_SETTLE: state_nx = ST_WAIT;
            default:   state_nx = ST_WAIT;
        endcase
    end

    // Buffer is frozen while the decoder samples it, hence no ready in LOAD.
    always_comb begin
        bus.oReady     = 1'b0;
        bus.oDecCE     = 1'b0;
        bus.ovCharData = CHAR_SPACE;
        if (!iReset) begin
            bus.oReady = (state != ST_LOAD);
            if (state == ST_LOAD) begin
                bus.oDecCE     = 1'b1;
                bus.ovCharData = char_buf[index];
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            index <= LAST_IDX;
            anode <= '1;
            segs  <= SEG_BLANK;
        end else begin
            if (state == ST_WAIT && tick) begin
                anode <= '1;
                index <= (index == LAST_IDX) ? '0 : index + 1'b1;
            end
            if (state == ST_SETTLE) begin
                segs  <= bus.ivSegments;
                anode <= ~(ONE_HOT0 << index);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            for (int i = 0; i < DIGITS; i++) char_buf[i] <= CHAR_SPACE;
        end else if (accept) begin
`ifdef SEG_SCAN_CTRL_EDIT_EN
            if (bus.ivData == CHAR_BS) begin
                for (int i = 0; i < DIGITS - 1; i++) char_buf[i] <= char_buf[i+1];
                char_buf[DIGITS-1] <= CHAR_SPACE;
            end else if (bus.ivData == CHAR_CR) begin
                for (int i = 0; i < DIGITS; i++) char_buf[i] <= CHAR_SPACE;
            end else begin
                char_buf[0] <= bus.ivData;
                for (int i = 1; i < DIGITS; i++) char_buf[i] <= char_buf[i-1];
            end
`else
            char_buf[0] <= bus.ivData;
            for (int i = 1; i < DIGITS; i++) char_buf[i] <= char_buf[i-1];
`endif
        end
    end

    assign bus.ovAnode    = anode;
    assign bus.ovSegments = segs;
endmodule
